uart_rx_frame_ctrl: RTL and testbench

Sequences the uart_rx byte receiver. Consumes each received byte through the available/clear_available handshake, delineates frames of the form SYNC, LEN, PAYLOAD[LEN], SUM, and streams the payload bytes downstream. Reports frame success or failure with a one-cycle pulse. Sits between uart_rx and the command/OFDM configuration logic.

---
 rtl/uart_rx_frame_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Purpose: frame delineator behind uart_rx (SYNC, LEN, PAYLOAD[LEN], SUM) that streams payload bytes and flags frame result.
// Latency: out_valid/frame_ok/frame_err one cycle after the rx_clear pulse that consumed the byte (rx_clear one cycle after take).
// Backpressure: none downstream; upstream paced by uart_rx available/clear_available. Inter-byte timeout under UART_RX_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl #(
    parameter int          CLK_FREQ      = 27_000_000,
    parameter int          BOUD_RATE     = 115200,
    parameter logic [7:0]  SYNC_BYTE     = 8'hAA,
    parameter int          MAX_LEN       = 16,
    parameter int          TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_available,
    output logic       rx_clear,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    // Ten bit times per UART byte (start + 8 data + stop).
    localparam int         TIMEOUT_CYCLES = (CLK_FREQ / BOUD_RATE) * 10 * TIMEOUT_BYTES;
    localparam logic [7:0] MAX_LEN_B      = 8'(MAX_LEN);

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_SUM     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Reject configurations the 8-bit length field or timer cannot represent.
    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("uart_rx_frame_ctrl: MAX_LEN must be 1..255 and the timeout must be nonzero");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_SUM
    } state_t;

    state_t     state_q, state_nx;
    logic [7:0] byte_q;
    logic       clear_d;
    logic       take;
    logic       proc;
    logic       tmo_hit;

    logic [7:0] len_q, len_nx;
    logic [7:0] cnt_q, cnt_nx;
    logic [7:0] sum_q, sum_nx;

    logic [7:0] out_data_nx;
    logic       out_valid_nx;
    logic       out_last_nx;
    logic       frame_ok_nx;
    logic       frame_err_nx;
    logic [1:0] err_code_nx;

    // uart_rx needs a cycle to drop its flag after clear, so the flag is
    // ignored while rx_clear is high and for one cycle after.
    assign take = rx_available && !rx_clear && !clear_d;

    // The latched byte is interpreted in the cycle rx_clear is high.
    assign proc = rx_clear;

    assign busy = (state_q != ST_IDLE);

    // Byte take: latch the data and pulse clear_available once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_clear <= 1'b0;
            clear_d  <= 1'b0;
            byte_q   <= 8'h00;
        end else begin
            rx_clear <= take;
            clear_d  <= rx_clear;
            if (take) begin
                byte_q <= rx_data;
            end
        end
    end

`ifdef UART_RX_FRAME_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] tmr_q;

    // Inter-byte timer: restarts on each take, runs only inside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else if (take || state_q == ST_IDLE) begin
            tmr_q <= '0;
        end else if (!tmo_hit) begin
            tmr_q <= tmr_q + 1'b1;
        end
    end

    // A take in the same cycle restarts the timer, so the byte wins.
    assign tmo_hit = (tmr_q == TMR_W'(TIMEOUT_CYCLES)) && !take;
`else
    assign tmo_hit = 1'b0;
`endif

    // Frame state register, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= 8'h00;
            cnt_q     <= 8'h00;
            sum_q     <= 8'h00;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state_q   <= state_nx;
            len_q     <= len_nx;
            cnt_q     <= cnt_nx;
            sum_q     <= sum_nx;
            out_data  <= out_data_nx;
            out_valid <= out_valid_nx;
            out_last  <= out_last_nx;
            frame_ok  <= frame_ok_nx;
            frame_err <= frame_err_nx;
            err_code  <= err_code_nx;
        end
    end

    // Next-state and output decode; only one result strobe per processed byte.
    always_comb begin
        state_nx     = state_q;
        len_nx       = len_q;
        cnt_nx       = cnt_q;
        sum_nx       = sum_q;
        out_data_nx  = out_data;
        out_valid_nx = 1'b0;
        out_last_nx  = 1'b0;
        frame_ok_nx  = 1'b0;
        frame_err_nx = 1'b0;
        err_code_nx  = err_code;

        if (proc) begin
            case (state_q)
                ST_IDLE: begin
                    // Anything other than SYNC between frames is noise.
                    if (byte_q == SYNC_BYTE) begin
                        state_nx = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (byte_q != 8'h00 && byte_q <= MAX_LEN_B) begin
                        len_nx   = byte_q;
                        sum_nx   = byte_q;
                        cnt_nx   = 8'h00;
                        state_nx = ST_PAYLOAD;
                    end else begin
                        frame_err_nx = 1'b1;
                        err_code_nx  = ERR_LEN;
                        state_nx     = ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    out_data_nx  = byte_q;
                    out_valid_nx = 1'b1;
                    sum_nx       = sum_q + byte_q;
                    cnt_nx       = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        out_last_nx = 1'b1;
                        state_nx    = ST_SUM;
                    end
                end
                ST_SUM: begin
                    if (byte_q == sum_q) begin
                        frame_ok_nx = 1'b1;
                    end else begin
                        frame_err_nx = 1'b1;
                        err_code_nx  = ERR_SUM;
                    end
                    state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end else if (tmo_hit) begin
            frame_err_nx = 1'b1;
            err_code_nx  = ERR_TIMEOUT;
            state_nx     = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Purpose: randomized and directed checks of uart_rx_frame_ctrl against a stream-level frame parser.
// Latency: bench emulates uart_rx, dropping available after the clear pulse (or after a fixed hold).
// Backpressure: none; every output strobe is captured by a negedge monitor.
module tb_uart_rx_frame_ctrl;

    localparam logic [7:0] SYNC = 8'hAA;
    localparam int         MAXL = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_available = 1'b0;
    logic       rx_clear;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(
        .CLK_FREQ     (27_000_000),
        .BOUD_RATE    (115200),
        .SYNC_BYTE    (SYNC),
        .MAX_LEN      (MAXL),
        .TIMEOUT_BYTES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_available(rx_available),
        .rx_clear    (rx_clear),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .busy        (busy)
    );

    int tests = 0;
    int fails = 0;

    // Observed traffic
    logic [8:0] obs_q[$];
    logic [1:0] err_q[$];
    int   ok_cnt = 0;
    int   clr_cnt = 0;
    int   clr_wide = 0;
    int   excl_viol = 0;
    int   lat_viol = 0;
    logic prev_clr = 1'b0;

    // Expected traffic
    logic [7:0] stim_q[$];
    logic [8:0] exp_obs[$];
    logic [1:0] exp_err[$];
    int   exp_ok;

    // Monitor sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rx_clear) clr_cnt++;
        if (rx_clear && prev_clr) clr_wide++;
        if (int'(out_valid) + int'(frame_ok) + int'(frame_err) > 1) excl_viol++;
        if (out_last && !out_valid) excl_viol++;
        if ((out_valid || frame_ok || (frame_err && err_code != 2'd3)) && !prev_clr) lat_viol++;
        if (out_valid) obs_q.push_back({out_last, out_data});
        if (frame_ok) ok_cnt++;
        if (frame_err) err_q.push_back(err_code);
        prev_clr = rx_clear;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Parse the whole byte stream by index arithmetic: frame = SYNC, LEN, LEN payload bytes, SUM.
    task automatic model();
        int         i;
        int         n;
        int         len;
        logic [7:0] s;
        exp_obs.delete();
        exp_err.delete();
        exp_ok = 0;
        i = 0;
        n = stim_q.size();
        while (i < n) begin
            if (stim_q[i] != SYNC) begin
                i++;
            end else if (i + 1 >= n) begin
                break;
            end else begin
                len = int'(stim_q[i+1]);
                if (len < 1 || len > MAXL) begin
                    exp_err.push_back(2'd1);
                    i += 2;
                end else if (i + 2 + len >= n) begin
                    break;
                end else begin
                    s = 8'(len);
                    for (int k = 0; k < len; k++) begin
                        s = s + stim_q[i+2+k];
                        exp_obs.push_back({(k == len - 1), stim_q[i+2+k]});
                    end
                    if (stim_q[i+2+len] == s) exp_ok++;
                    else exp_err.push_back(2'd2);
                    i += 3 + len;
                end
            end
        end
    endtask

    // uart_rx stand-in: raise available, then drop it after clear (hold==0) or after hold cycles.
    task automatic send_byte(input logic [7:0] b, input int hold);
        logic got;
        @(negedge clk);
        rx_data = b;
        rx_available = 1'b1;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
        end else begin
            got = 1'b0;
            for (int k = 0; k < 16 && !got; k++) begin
                @(posedge clk);
                #1;
                got = rx_clear;
            end
            chk("rx_clear_seen", got, 1);
            @(negedge clk);
        end
        rx_available = 1'b0;
    endtask

    task automatic run_stream(input string tag, input int hold, input int pause_at, input int pause_len);
        int ob, eb, ok0, cl0;
        ob  = obs_q.size();
        eb  = err_q.size();
        ok0 = ok_cnt;
        cl0 = clr_cnt;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (i == pause_at) repeat (pause_len) @(negedge clk);
            send_byte(stim_q[i], hold);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        model();
        chk({tag, ":n_out"}, obs_q.size() - ob, exp_obs.size());
        for (int k = 0; k < exp_obs.size(); k++)
            chk({tag, ":out"}, (ob + k < obs_q.size()) ? 32'(obs_q[ob+k]) : 32'hDEAD, 32'(exp_obs[k]));
        chk({tag, ":n_ok"}, ok_cnt - ok0, exp_ok);
        chk({tag, ":n_err"}, err_q.size() - eb, exp_err.size());
        for (int k = 0; k < exp_err.size(); k++)
            chk({tag, ":err_code"}, (eb + k < err_q.size()) ? 32'(err_q[eb+k]) : 32'hDEAD, 32'(exp_err[k]));
        chk({tag, ":n_clear"}, clr_cnt - cl0, stim_q.size());
        chk({tag, ":busy_end"}, busy, 0);
    endtask

    task automatic gen_unit(input int kind);
        int         len;
        logic [7:0] s;
        logic [7:0] b;
        case (kind)
            0: begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h55;
                stim_q.push_back(b);
            end
            1, 2: begin
                len = ($urandom_range(0, 3) == 0) ? MAXL : int'($urandom_range(1, MAXL));
                stim_q.push_back(SYNC);
                stim_q.push_back(8'(len));
                s = 8'(len);
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom_range(0, 255));
                    s = s + b;
                    stim_q.push_back(b);
                end
                if (kind == 2) s = s + 8'($urandom_range(1, 255));
                stim_q.push_back(s);
            end
            default: begin
                stim_q.push_back(SYNC);
                stim_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
            end
        endcase
    endtask

    initial begin
        int e0;
        int c;
        logic [7:0] s;

        // Reset state
        #12;
        chk("reset_outs", {rx_clear, out_data, out_valid, out_last, frame_ok, frame_err, err_code, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame
        stim_q = '{8'hAA, 8'h03, 8'h41, 8'h42, 8'h43, 8'hC9};
        run_stream("good", 0, -1, 0);
        chk("good_last_byte", obs_q[obs_q.size()-1], {1'b1, 8'h43});

        // Bad checksum
        stim_q = '{8'hAA, 8'h02, 8'h10, 8'h20, 8'h00};
        run_stream("bad_sum", 0, -1, 0);
        chk("bad_sum_code", err_code, 2);

        // Length errors
        stim_q = '{8'hAA, 8'h00};
        run_stream("len_zero", 0, -1, 0);
        chk("len_zero_code", err_code, 1);
        stim_q = '{8'hAA, 8'h11};
        run_stream("len_over", 0, -1, 0);
        chk("len_over_code", err_code, 1);

        // Maximum length accepted
        stim_q = '{8'hAA, 8'h10};
        s = 8'h10;
        for (int k = 0; k < MAXL; k++) begin
            stim_q.push_back(8'(k * 7 + 3));
            s = s + 8'(k * 7 + 3);
        end
        stim_q.push_back(s);
        e0 = ok_cnt;
        run_stream("len_max", 0, -1, 0);
        chk("len_max_ok", ok_cnt - e0, 1);

        // Garbage then frame, SYNC value as payload
        stim_q = '{8'h55, 8'h00, 8'hAA, 8'h01, 8'hAA, 8'hAB};
        run_stream("garbage", 0, -1, 0);
        chk("garbage_payload", obs_q[obs_q.size()-1], {1'b1, 8'hAA});

        // Available held for 3 cycles per byte
        stim_q = '{8'hAA, 8'h03, 8'h41, 8'h42, 8'h43, 8'hC9};
        run_stream("held3", 3, -1, 0);

        // Long mid-frame pause
        stim_q = '{8'hAA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
`ifdef UART_RX_FRAME_TIMEOUT_EN
        run_stream("pause", 0, 3, 1000);
`else
        run_stream("pause", 0, 3, 12000);
`endif

        // Reset mid-payload
        send_byte(8'hAA, 0);
        send_byte(8'h05, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        e0 = err_q.size();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {rx_clear, out_data, out_valid, out_last, frame_ok, frame_err, err_code, busy}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_err", err_q.size() - e0, 0);
        stim_q = '{8'hAA, 8'h01, 8'h7F, 8'h80};
        run_stream("after_rst", 0, -1, 0);

`ifdef UART_RX_FRAME_TIMEOUT_EN
        // Inter-byte timeout
        send_byte(8'hAA, 0);
        send_byte(8'h03, 0);
        send_byte(8'h41, 0);
        e0 = err_q.size();
        c = 0;
        while (c < 9600 && err_q.size() == e0) begin
            @(negedge clk);
            c++;
        end
        chk("tmo_n_err", err_q.size() - e0, 1);
        chk("tmo_code", (err_q.size() > e0) ? 32'(err_q[e0]) : 32'hDEAD, 3);
        chk("tmo_window", (c >= 9300 && c <= 9400), 1);
        @(negedge clk);
        chk("tmo_busy", busy, 0);
`endif

        // Randomized streams
        for (int t = 0; t < 30; t++) begin
            stim_q.delete();
            for (int u = 0; u < int'($urandom_range(1, 4)); u++)
                gen_unit(int'($urandom_range(0, 3)));
            run_stream("rand", 0, -1, 0);
        end

        chk("clear_width", clr_wide, 0);
        chk("strobe_exclusive", excl_viol, 0);
        chk("strobe_latency", lat_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
